load_ext: RTL and testbench
===========================

Name: load_ext

Overview:
- Load-path counterpart of the store trimmer: issues one memory read per CPU load request, waits for the memory acknowledge, and extracts the loaded item from the returned word.
- Byte loads take MEM_DIN[31:24]; halfword loads take MEM_DIN[31:16]. This MSB-aligned placement matches the store path.
- The item is zero- or sign-extended to 32 bits and held for the register-file writeback.
- Sits between the single-cycle CPU's load control and the data memory port. Stalls the CPU while a read is outstanding and flags reads that time out.

Parameters:
- TIMEOUT, 16, cycles to wait for MEM_ACK before abandoning the read (legal range 2..255).
- CNT_W, 8, width of the timeout counter.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- REQ  input  1  load request; sampled only in IDLE.
- ADDR  input  32  byte address of the load.
- CTL  input  2  access size: 2'b01 byte, 2'b10 halfword, 2'b00 or 2'b11 word.
- SGN  input  1  1 = sign-extend, 0 = zero-extend; ignored for word loads.
- MEM_RD  output  1  read strobe to memory, held high while waiting.
- MEM_ADDR  output  32  address driven to memory, registered.
- MEM_ACK  input  1  memory acknowledge; MEM_DIN is valid in the same cycle.
- MEM_DIN  input  32  read data from memory.
- BUSY  output  1  CPU stall, high from the accept cycle until DONE.
- VALID  output  1  one-cycle pulse: DOUT holds a new result.
- ERR  output  1  one-cycle pulse: load abandoned.
- DOUT  output  32  extended load result, held until the next VALID.

Behaviour:
- Reset (asynchronous, RST_N low):
  - State = IDLE.
  - MEM_RD, BUSY, VALID, ERR = 0.
  - MEM_ADDR = 0, DOUT = 0, counter = 0.
- States: IDLE, WAIT, DONE.
- IDLE, REQ=1:
  - Register ADDR into MEM_ADDR; latch CTL and SGN.
  - Clear the counter; set MEM_RD=1 and BUSY=1; go to WAIT.
  - MEM_RD first appears the cycle after REQ.
- WAIT, MEM_ACK=1:
  - Capture the extended data into DOUT.
  - MEM_RD=0; go to DONE.
- WAIT, MEM_ACK=0:
  - Counter increments.
  - When the counter reaches TIMEOUT-1 with no ACK: MEM_RD=0, DOUT unchanged, pulse ERR, go to DONE.
- DONE:
  - VALID=1 if the load completed, otherwise ERR=1 (never both).
  - BUSY=0 at the next edge; return to IDLE.
- Latency: REQ at cycle 0, ACK at cycle k (k>=1) -> VALID at cycle k+1. Minimum 2 cycles.
- Extension rules:
  - Byte: DOUT = {24{SGN & MEM_DIN[31]}, MEM_DIN[31:24]}.
  - Halfword: DOUT = {16{SGN & MEM_DIN[31]}, MEM_DIN[31:16]}.
  - Word: DOUT = MEM_DIN.
- Boundary cases:
  - REQ while BUSY: ignored, not queued.
  - ACK in IDLE or DONE: ignored.
  - ACK in the same cycle the counter reaches its limit: ACK wins, completes normally.
  - Request inputs changing after acceptance: no effect.
  - Back-to-back: REQ may be accepted in the IDLE cycle immediately after DONE.
  - RST_N asserted mid-read: immediate return to reset values, no VALID or ERR, outstanding MEM_RD dropped.

Optional Feature:
- Macro: LOAD_EXT_ALIGN_CHK_EN.
- Defined:
  - In IDLE, a REQ with CTL=halfword and ADDR[0]=1, or CTL=word and ADDR[1:0]!=0, is misaligned.
  - A misaligned REQ goes directly to DONE with MEM_RD never asserted.
  - BUSY is high for one cycle, then ERR pulses; DOUT is unchanged.
- Undefined: no alignment check; ADDR passes to MEM_ADDR unchanged for every access size.

Test Plan:
- Reset then idle: RST_N low with REQ toggling -> all outputs 0. Release -> MEM_RD stays 0 until REQ.
- Signed byte: REQ, CTL=01, SGN=1, ADDR=0x100; ACK after 3 cycles with MEM_DIN=0x80AABBCC -> MEM_ADDR=0x100, VALID 4 cycles after REQ, DOUT=0xFFFFFF80.
- Unsigned halfword and word:
  - CTL=10, SGN=0, MEM_DIN=0xF00D1234, ACK in first WAIT cycle -> DOUT=0x0000F00D, VALID 2 cycles after REQ.
  - CTL=00, SGN=1, same data -> DOUT=0xF00D1234.
- Timeout: TIMEOUT=16, never ACK -> MEM_RD high 16 cycles, ERR pulse, no VALID, DOUT keeps its previous value. A late ACK afterwards is ignored.
- Collisions:
  - REQ held high during BUSY -> exactly one MEM_RD burst per acceptance.
  - ACK on the final timeout cycle -> VALID, not ERR.
  - RST_N pulsed low during WAIT -> MEM_RD and BUSY drop asynchronously.
- With LOAD_EXT_ALIGN_CHK_EN defined: halfword load at ADDR=0x103 -> MEM_RD never asserted, ERR 1 cycle after REQ. Without the macro: same stimulus -> MEM_ADDR=0x103 and a normal read.

Source files
------------

// File: rtl/load_ext_if.sv
// rtl/load_ext_if.sv - CPU load request and data-memory read port bundle for load_ext.
interface load_ext_if;
  logic        REQ;
  logic [31:0] ADDR;
  logic [1:0]  CTL;
  logic        SGN;
  logic        MEM_RD;
  logic [31:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [31:0] MEM_DIN;
  logic        BUSY;
  logic        VALID;
  logic        ERR;
  logic [31:0] DOUT;

  modport master (
    output REQ, ADDR, CTL, SGN, MEM_ACK, MEM_DIN,
    input  MEM_RD, MEM_ADDR, BUSY, VALID, ERR, DOUT
  );

  modport slave (
    input  REQ, ADDR, CTL, SGN, MEM_ACK, MEM_DIN,
    output MEM_RD, MEM_ADDR, BUSY, VALID, ERR, DOUT
  );
endinterface

// File: rtl/load_ext.sv
// rtl/load_ext.sv - load path: one memory read per request, MSB-aligned extract, zero/sign extend.
// Optional alignment check enabled by defining LOAD_EXT_ALIGN_CHK_EN.
module load_ext #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  load_ext_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        addr_q;
  logic [31:0]        dout_q;
  logic [1:0]         ctl_q;
  logic               sgn_q;
  logic               ok_q;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        ext_data;
  logic               misaligned;

`ifdef LOAD_EXT_ALIGN_CHK_EN
  always_comb begin
    misaligned = 1'b0;
    if (bus.CTL == 2'b10)
      misaligned = bus.ADDR[0];
    else if (bus.CTL == 2'b00 || bus.CTL == 2'b11)
      misaligned = (bus.ADDR[1:0] != 2'b00);
  end
`else
  assign misaligned = 1'b0;
`endif

  // Sub-word items live at the top of the returned word, matching the store path.
  always_comb begin
    ext_data = bus.MEM_DIN;
    case (ctl_q)
      2'b01:   ext_data = {{24{sgn_q & bus.MEM_DIN[31]}}, bus.MEM_DIN[31:24]};
      2'b10:   ext_data = {{16{sgn_q & bus.MEM_DIN[31]}}, bus.MEM_DIN[31:16]};
      default: ext_data = bus.MEM_DIN;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.REQ) state_nxt = misaligned ? S_DONE : S_WAIT;
      S_WAIT: if (bus.MEM_ACK || cnt == LIMIT) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.MEM_RD = (state == S_WAIT);
    bus.BUSY   = (state == S_WAIT) || (state == S_DONE);
    bus.VALID  = (state == S_DONE) && ok_q;
    bus.ERR    = (state == S_DONE) && !ok_q;
  end

  // ok_q records how the read ended; ACK on the limit cycle still completes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q <= '0;
      dout_q <= '0;
      ctl_q  <= '0;
      sgn_q  <= 1'b0;
      ok_q   <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.REQ) begin
            addr_q <= bus.ADDR;
            ctl_q  <= bus.CTL;
            sgn_q  <= bus.SGN;
            ok_q   <= 1'b0;
            cnt    <= '0;
          end
        end
        S_WAIT: begin
          if (bus.MEM_ACK) begin
            dout_q <= ext_data;
            ok_q   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.MEM_ADDR = addr_q;
  assign bus.DOUT     = dout_q;

endmodule

// File: tb/tb_load_ext.sv
// tb/tb_load_ext.sv - directed self-checking bench for load_ext.
module tb_load_ext;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   cnt;

  load_ext_if bus ();

  load_ext #(.TIMEOUT(16), .CNT_W(8)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [1:0] c, input logic s);
    bus.REQ  = 1'b1;
    bus.ADDR = a;
    bus.CTL  = c;
    bus.SGN  = s;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.REQ = 1'b0; bus.ADDR = 32'h0; bus.CTL = 2'b00; bus.SGN = 1'b0;
    bus.MEM_ACK = 1'b0; bus.MEM_DIN = 32'h0;

    // reset with REQ toggling
    for (int i = 0; i < 4; i++) begin
      bus.REQ = ~bus.REQ;
      bus.ADDR = 32'h55 + i;
      tick();
    end
    check("rst_mem_rd", bus.MEM_RD, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_valid", bus.VALID, 0);
    check("rst_err", bus.ERR, 0);
    check("rst_mem_addr", bus.MEM_ADDR, 32'h0);
    check("rst_dout", bus.DOUT, 32'h0);
    bus.REQ = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    check("idle_mem_rd", bus.MEM_RD, 0);

    // ACK in IDLE ignored
    bus.MEM_ACK = 1'b1; bus.MEM_DIN = 32'hDEADBEEF;
    tick();
    bus.MEM_ACK = 1'b0;
    tick();
    check("idle_ack_valid", bus.VALID, 0);
    check("idle_ack_dout", bus.DOUT, 32'h0);

    // signed byte, ACK 3 cycles after REQ
    drive_req(32'h100, 2'b01, 1'b1);
    tick();
    bus.REQ = 1'b0;
    check("sb_mem_rd", bus.MEM_RD, 1);
    check("sb_busy", bus.BUSY, 1);
    check("sb_mem_addr", bus.MEM_ADDR, 32'h100);
    tick();
    tick();
    bus.MEM_ACK = 1'b1; bus.MEM_DIN = 32'h80AABBCC;
    tick();
    bus.MEM_ACK = 1'b0;
    check("sb_valid", bus.VALID, 1);
    check("sb_err", bus.ERR, 0);
    check("sb_mem_rd_off", bus.MEM_RD, 0);
    check("sb_dout", bus.DOUT, 32'hFFFFFF80);
    tick();
    check("sb_valid_pulse", bus.VALID, 0);
    check("sb_busy_off", bus.BUSY, 0);

    // unsigned halfword, ACK in first WAIT cycle
    drive_req(32'h200, 2'b10, 1'b0);
    tick();
    bus.REQ = 1'b0;
    bus.MEM_ACK = 1'b1; bus.MEM_DIN = 32'hF00D1234;
    tick();
    bus.MEM_ACK = 1'b0;
    check("uh_valid", bus.VALID, 1);
    check("uh_dout", bus.DOUT, 32'h0000F00D);
    tick();

    // signed halfword
    drive_req(32'h204, 2'b10, 1'b1);
    tick();
    bus.REQ = 1'b0;
    bus.MEM_ACK = 1'b1; bus.MEM_DIN = 32'h80001234;
    tick();
    bus.MEM_ACK = 1'b0;
    check("sh_dout", bus.DOUT, 32'hFFFF8000);
    tick();

    // unsigned byte with MSB set
    drive_req(32'h208, 2'b01, 1'b0);
    tick();
    bus.REQ = 1'b0;
    bus.MEM_ACK = 1'b1; bus.MEM_DIN = 32'hF0123456;
    tick();
    bus.MEM_ACK = 1'b0;
    check("ub_dout", bus.DOUT, 32'h000000F0);
    tick();

    // word with SGN=1, CTL=00
    drive_req(32'h20C, 2'b00, 1'b1);
    tick();
    bus.REQ = 1'b0;
    bus.MEM_ACK = 1'b1; bus.MEM_DIN = 32'hF00D1234;
    tick();
    bus.MEM_ACK = 1'b0;
    check("w_dout", bus.DOUT, 32'hF00D1234);
    tick();

    // word with CTL=11
    drive_req(32'h210, 2'b11, 1'b1);
    tick();
    bus.REQ = 1'b0;
    bus.MEM_ACK = 1'b1; bus.MEM_DIN = 32'h8765ABCD;
    tick();
    bus.MEM_ACK = 1'b0;
    check("w11_dout", bus.DOUT, 32'h8765ABCD);
    tick();

    // timeout: no ACK
    drive_req(32'h300, 2'b00, 1'b0);
    tick();
    bus.REQ = 1'b0;
    cnt = 0;
    while (bus.MEM_RD === 1'b1 && cnt < 40) begin
      check("to_no_valid", bus.VALID, 0);
      cnt++;
      tick();
    end
    check("to_rd_cycles", cnt, 16);
    check("to_err", bus.ERR, 1);
    check("to_valid", bus.VALID, 0);
    check("to_dout_kept", bus.DOUT, 32'h8765ABCD);
    tick();
    check("to_err_pulse", bus.ERR, 0);
    bus.MEM_ACK = 1'b1; bus.MEM_DIN = 32'h12345678;
    tick();
    bus.MEM_ACK = 1'b0;
    check("late_ack_valid", bus.VALID, 0);
    check("late_ack_rd", bus.MEM_RD, 0);
    check("late_ack_dout", bus.DOUT, 32'h8765ABCD);
    tick();

    // REQ held during BUSY, inputs changed after acceptance
    drive_req(32'h400, 2'b01, 1'b1);
    tick();
    check("hold_rd", bus.MEM_RD, 1);
    bus.ADDR = 32'h999; bus.CTL = 2'b00; bus.SGN = 1'b0;
    tick();
    bus.MEM_ACK = 1'b1; bus.MEM_DIN = 32'h7F123456;
    tick();
    bus.MEM_ACK = 1'b0;
    check("hold_valid", bus.VALID, 1);
    check("hold_rd_off", bus.MEM_RD, 0);
    check("hold_addr", bus.MEM_ADDR, 32'h400);
    check("hold_dout", bus.DOUT, 32'h0000007F);
    tick();
    check("hold_idle_rd", bus.MEM_RD, 0);
    check("hold_idle_busy", bus.BUSY, 0);
    tick();
    bus.REQ = 1'b0;
    check("b2b_rd", bus.MEM_RD, 1);
    check("b2b_addr", bus.MEM_ADDR, 32'h999);
    bus.MEM_ACK = 1'b1; bus.MEM_DIN = 32'h11223344;
    tick();
    bus.MEM_ACK = 1'b0;
    check("b2b_dout", bus.DOUT, 32'h11223344);
    tick();

    // ACK on the final timeout cycle
    drive_req(32'h500, 2'b00, 1'b0);
    tick();
    bus.REQ = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("edge_rd", bus.MEM_RD, 1);
    bus.MEM_ACK = 1'b1; bus.MEM_DIN = 32'hCAFEF00D;
    tick();
    bus.MEM_ACK = 1'b0;
    check("edge_valid", bus.VALID, 1);
    check("edge_err", bus.ERR, 0);
    check("edge_dout", bus.DOUT, 32'hCAFEF00D);
    tick();

    // reset pulsed during WAIT
    drive_req(32'h600, 2'b00, 1'b0);
    tick();
    bus.REQ = 1'b0;
    tick();
    check("mid_rd_before", bus.MEM_RD, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rd_async", bus.MEM_RD, 0);
    check("mid_busy_async", bus.BUSY, 0);
    check("mid_dout", bus.DOUT, 32'h0);
    check("mid_addr", bus.MEM_ADDR, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_valid", bus.VALID, 0);
    check("mid_err", bus.ERR, 0);
    tick();

    // misaligned halfword
    drive_req(32'h103, 2'b10, 1'b0);
    tick();
    bus.REQ = 1'b0;
`ifdef LOAD_EXT_ALIGN_CHK_EN
    check("mis_rd", bus.MEM_RD, 0);
    check("mis_busy", bus.BUSY, 1);
    check("mis_err", bus.ERR, 1);
    check("mis_valid", bus.VALID, 0);
    tick();
    check("mis_busy_off", bus.BUSY, 0);
    check("mis_dout", bus.DOUT, 32'h0);
`else
    check("mis_rd", bus.MEM_RD, 1);
    check("mis_addr", bus.MEM_ADDR, 32'h103);
    bus.MEM_ACK = 1'b1; bus.MEM_DIN = 32'h8001FFFF;
    tick();
    bus.MEM_ACK = 1'b0;
    check("mis_valid", bus.VALID, 1);
    check("mis_dout", bus.DOUT, 32'h00008001);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
